// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a dual-pointer FIFO RAM.
// Define FIFO_STICKY_ERR_EN to make overflow_err/underflow_err hold until reset.
module fifo_ctrl #(
    parameter int DATA_SIZE = 3
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_SIZE-1:0] thr_af,
    input  logic [DATA_SIZE-1:0] thr_ae,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [DATA_SIZE-1:0] wr_ptr,
    output logic [DATA_SIZE-1:0] rd_ptr,
    output logic [DATA_SIZE-1:0] count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 data_valid,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    // One slot stays unused: the RAM zeroes wr_ptr whenever write is low.
    localparam logic [DATA_SIZE-1:0] MAX_COUNT = {DATA_SIZE{1'b1}};

    logic pop_acc;
    logic push_acc;

    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    assign mem_write = push_acc;
    assign mem_read  = pop_acc;

    assign full         = (count == MAX_COUNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= thr_af);
    assign almost_empty = (count <= thr_ae);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_acc && !pop_acc)
                count <= count + 1'b1;
            else if (pop_acc && !push_acc)
                count <= count - 1'b1;
            data_valid <= pop_acc;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            overflow_err  <= overflow_err  | (push & ~push_acc);
            underflow_err <= underflow_err | (pop & empty);
`else
            overflow_err  <= push & ~push_acc;
            underflow_err <= pop & empty;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized scoreboard bench for fifo_ctrl with a behavioural RAM and queue model.
module tb_fifo_ctrl;

    localparam int DS  = 3;
    localparam int DEP = 8;
    localparam int CAP = 7;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          push, pop;
    logic [DS-1:0] thr_af, thr_ae;
    logic          mem_write, mem_read;
    logic [DS-1:0] wr_ptr, rd_ptr, count;
    logic          full, empty, almost_full, almost_empty;
    logic          data_valid, overflow_err, underflow_err;

    fifo_ctrl #(.DATA_SIZE(DS)) dut (
        .clk(clk), .reset_L(reset_L), .push(push), .pop(pop),
        .thr_af(thr_af), .thr_ae(thr_ae),
        .mem_write(mem_write), .mem_read(mem_read),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .data_valid(data_valid), .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural RAM: registered read, location zeroed whenever write is low.
    logic [7:0] ram [DEP];
    logic [7:0] wdata;
    logic [7:0] data_out;

    always @(posedge clk) begin
        if (mem_write) ram[wr_ptr] <= wdata;
        else           ram[wr_ptr] <= 8'h00;
        if (mem_read)  data_out <= ram[rd_ptr];
    end

    // Reference model
    logic [7:0] sb_q[$];
    int  m_cnt, m_wr, m_rd;
    bit  m_dv, m_ov, m_un;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_wr = 0; m_rd = 0;
        m_dv = 0; m_ov = 0; m_un = 0;
        sb_q.delete();
    endtask

    task automatic check_state(input bit exp_w, input bit exp_r);
        chk("mem_write", mem_write, exp_w);
        chk("mem_read", mem_read, exp_r);
        chk("count", count, m_cnt);
        chk("wr_ptr", wr_ptr, m_wr);
        chk("rd_ptr", rd_ptr, m_rd);
        chk("full", full, m_cnt == CAP);
        chk("empty", empty, m_cnt == 0);
        chk("almost_full", almost_full, m_cnt >= int'(thr_af));
        chk("almost_empty", almost_empty, m_cnt <= int'(thr_ae));
        chk("data_valid", data_valid, m_dv);
        chk("overflow_err", overflow_err, m_ov);
        chk("underflow_err", underflow_err, m_un);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input bit p, input bit q);
        bit pa, wa;
        push  = p;
        pop   = q;
        wdata = 8'($urandom_range(1, 255));
        @(negedge clk);
        pa = q && (m_cnt > 0);
        wa = p && ((m_cnt < CAP) || pa);
        check_state(wa, pa);
        @(posedge clk);
`ifdef FIFO_STICKY_ERR_EN
        m_ov = m_ov | (p && !wa);
        m_un = m_un | (q && (m_cnt == 0));
`else
        m_ov = p && !wa;
        m_un = q && (m_cnt == 0);
`endif
        if (wa) begin
            sb_q.push_back(wdata);
            m_wr = (m_wr + 1) % DEP;
        end
        if (pa) m_rd = (m_rd + 1) % DEP;
        m_cnt = m_cnt + int'(wa) - int'(pa);
        m_dv  = pa;
        #1;
    endtask

    task automatic do_reset();
        push = 1'b0;
        pop  = 1'b0;
        reset_L = 1'b0;
        #1;
        model_clear();
        check_state(1'b0, 1'b0);
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid read must return the oldest pushed word.
    always @(negedge clk) begin
        if (reset_L && data_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_data: data_valid with no word outstanding at %0t", $time);
            end else begin
                chk("read_data", data_out, sb_q.pop_front());
            end
        end
    end

    initial begin
        push = 0; pop = 0; wdata = 0;
        thr_af = 0; thr_ae = 0;
        reset_L = 1'b0;
        model_clear();
        #2;
        check_state(1'b0, 1'b0);
        @(posedge clk); #1;
        do_reset();

        // Pop from empty, then push+pop while empty (no bypass)
        cycle(0, 1);
        cycle(1, 1);
        cycle(0, 1);
        cycle(0, 0);

        // Fill, overflow, full push+pop with pointer wrap
        do_reset();
        repeat (CAP) cycle(1, 0);
        cycle(1, 0);
        cycle(0, 0);
        repeat (3) cycle(1, 1);
        cycle(0, 0);
        cycle(0, 0);

        // Thresholds
        thr_af = 3'd5;
        thr_ae = 3'd1;
        do_reset();
        repeat (6) cycle(1, 0);
        cycle(0, 0);

        // Asynchronous reset mid-operation at count 4 with push held
        do_reset();
        repeat (4) cycle(1, 0);
        push = 1'b1;
        #1 reset_L = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_wr_ptr", wr_ptr, 0);
        chk("async_rst_rd_ptr", rd_ptr, 0);
        chk("async_rst_empty", empty, 1);
        #1 reset_L = 1'b1;
        model_clear();
        cycle(1, 0);
        chk("post_rst_count", count, 1);

        // Randomized traffic with changing thresholds
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                thr_af = 3'($urandom);
                thr_ae = 3'($urandom);
            end
            if (i < 200)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
            else if (i < 400)
                cycle($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
            else
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (10) cycle(0, 1);
        cycle(0, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
